// File: rtl/fu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fu_pkg                                                 |
// | Brief   : Shared FU result types, default widths and helpers.    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package fu_pkg;

  localparam int NUM_FU = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;

  typedef logic [ID_W-1:0]   robid_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    robid_t id;
    data_t  val;
  } cdb_msg_t;

  typedef struct packed {
    robid_t robid;
    data_t  flags;
    data_t  wbs;
    data_t  value;
  } rob_msg_t;

  // Next index after idx, wrapping back to 0 past n-1.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rr_arbiter                                             |
// | Brief   : Round-robin one-hot arbiter with internal pointer.     |
// |           Grant depends only on req/en/ptr, never on payload.    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module rr_arbiter
  import fu_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PTR_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             en,
  output logic [WIDTH-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_idx;
  logic [WIDTH-1:0] w_grant;
  logic             w_found;
  logic             w_en;
  int               w_scan;

  // Nothing is granted while reset is held.
  assign w_en = en & ~rst;

  // Scan ptr, ptr+1, ... modulo WIDTH; first set request wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_scan  = 0;
    for (int k = 0; k < WIDTH; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= WIDTH) w_scan = w_scan - WIDTH;
      if (!w_found && req[w_scan[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_scan[PTR_W-1:0];
      end
    end
    if (w_found && w_en) w_grant[w_idx] = 1'b1;
  end

  // Pointer moves just past the winner; unchanged when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found && w_en) begin
      r_ptr <= PTR_W'(wrap_inc(int'(w_idx), WIDTH));
    end
  end

  assign grant     = w_grant;
  assign grant_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/fu_result_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fu_result_arbiter                                      |
// | Brief   : Round-robin sharing of the CDB and ROB writeback       |
// |           channels among NUM_FU functional units; registers the  |
// |           winner's payload onto each shared bus.                 |
// | Options : RESULT_ARB_STATS_EN adds saturating conflict counters. |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module fu_result_arbiter #(
  parameter int NUM_FU = 4,
  parameter int ID_W   = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        cdb_req,
  input  logic [NUM_FU*ID_W-1:0]   cdb_req_id,
  input  logic [NUM_FU*DATA_W-1:0] cdb_req_val,
  output logic [NUM_FU-1:0]        cdb_grant,
  output logic                     cdb_valid,
  output logic [ID_W-1:0]          cdb_id,
  output logic [DATA_W-1:0]        cdb_val,
  input  logic [NUM_FU-1:0]        rob_req,
  input  logic [NUM_FU*ID_W-1:0]   rob_req_robid,
  input  logic [NUM_FU*DATA_W-1:0] rob_req_flags,
  input  logic [NUM_FU*DATA_W-1:0] rob_req_wbs,
  input  logic [NUM_FU*DATA_W-1:0] rob_req_value,
  input  logic                     rob_ready,
  output logic [NUM_FU-1:0]        rob_grant,
  output logic                     rob_valid,
  output logic [ID_W-1:0]          rob_robid,
  output logic [DATA_W-1:0]        rob_flags,
  output logic [DATA_W-1:0]        rob_wbs,
  output logic [DATA_W-1:0]        rob_value
`ifdef RESULT_ARB_STATS_EN
  ,
  output logic [7:0]               cdb_conflicts,
  output logic [7:0]               rob_conflicts
`endif
);

  import fu_pkg::*;

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0] w_cdb_grant;
  logic [NUM_FU-1:0] w_rob_grant;
  logic [PTR_W-1:0]  w_cdb_idx;
  logic [PTR_W-1:0]  w_rob_idx;

  logic              r_cdb_valid;
  logic [ID_W-1:0]   r_cdb_id;
  logic [DATA_W-1:0] r_cdb_val;
  logic              r_rob_valid;
  logic [ID_W-1:0]   r_rob_robid;
  logic [DATA_W-1:0] r_rob_flags;
  logic [DATA_W-1:0] r_rob_wbs;
  logic [DATA_W-1:0] r_rob_value;

  rr_arbiter #(.WIDTH(NUM_FU)) u_cdb_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (cdb_req),
    .en        (1'b1),
    .grant     (w_cdb_grant),
    .grant_idx (w_cdb_idx)
  );

  rr_arbiter #(.WIDTH(NUM_FU)) u_rob_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (rob_req),
    .en        (rob_ready),
    .grant     (w_rob_grant),
    .grant_idx (w_rob_idx)
  );

  // CDB broadcast register: payload captured only on a grant, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_id    <= '0;
      r_cdb_val   <= '0;
    end else begin
      r_cdb_valid <= |w_cdb_grant;
      if (|w_cdb_grant) begin
        r_cdb_id  <= cdb_req_id[w_cdb_idx*ID_W +: ID_W];
        r_cdb_val <= cdb_req_val[w_cdb_idx*DATA_W +: DATA_W];
      end
    end
  end

  // ROB write register: same capture/hold behaviour as the CDB side.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rob_valid <= 1'b0;
      r_rob_robid <= '0;
      r_rob_flags <= '0;
      r_rob_wbs   <= '0;
      r_rob_value <= '0;
    end else begin
      r_rob_valid <= |w_rob_grant;
      if (|w_rob_grant) begin
        r_rob_robid <= rob_req_robid[w_rob_idx*ID_W +: ID_W];
        r_rob_flags <= rob_req_flags[w_rob_idx*DATA_W +: DATA_W];
        r_rob_wbs   <= rob_req_wbs[w_rob_idx*DATA_W +: DATA_W];
        r_rob_value <= rob_req_value[w_rob_idx*DATA_W +: DATA_W];
      end
    end
  end

`ifdef RESULT_ARB_STATS_EN
  logic [7:0] r_cdb_conflicts;
  logic [7:0] r_rob_conflicts;
  logic       w_cdb_conflict;
  logic       w_rob_conflict;

  // A conflict is any cycle where some requester is kept waiting.
  assign w_cdb_conflict = ($countones(cdb_req) > 1);
  assign w_rob_conflict = ($countones(rob_req) > 1) || ((|rob_req) && !rob_ready);

  // Saturating conflict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_conflicts <= '0;
      r_rob_conflicts <= '0;
    end else begin
      if (w_cdb_conflict) r_cdb_conflicts <= sat_inc8(r_cdb_conflicts);
      if (w_rob_conflict) r_rob_conflicts <= sat_inc8(r_rob_conflicts);
    end
  end

  assign cdb_conflicts = r_cdb_conflicts;
  assign rob_conflicts = r_rob_conflicts;
`endif

  assign cdb_grant = w_cdb_grant;
  assign cdb_valid = r_cdb_valid;
  assign cdb_id    = r_cdb_id;
  assign cdb_val   = r_cdb_val;
  assign rob_grant = w_rob_grant;
  assign rob_valid = r_rob_valid;
  assign rob_robid = r_rob_robid;
  assign rob_flags = r_rob_flags;
  assign rob_wbs   = r_rob_wbs;
  assign rob_value = r_rob_value;

endmodule
`default_nettype wire

// File: tb/tb_fu_result_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_fu_result_arbiter                                   |
// | Brief   : Directed self-checking bench for fu_result_arbiter.    |
// |           Define RESULT_ARB_STATS_EN to cover the counters.      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_fu_result_arbiter;

  localparam int NUM_FU = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_FU-1:0]        cdb_req;
  logic [NUM_FU*ID_W-1:0]   cdb_req_id;
  logic [NUM_FU*DATA_W-1:0] cdb_req_val;
  logic [NUM_FU-1:0]        cdb_grant;
  logic                     cdb_valid;
  logic [ID_W-1:0]          cdb_id;
  logic [DATA_W-1:0]        cdb_val;
  logic [NUM_FU-1:0]        rob_req;
  logic [NUM_FU*ID_W-1:0]   rob_req_robid;
  logic [NUM_FU*DATA_W-1:0] rob_req_flags;
  logic [NUM_FU*DATA_W-1:0] rob_req_wbs;
  logic [NUM_FU*DATA_W-1:0] rob_req_value;
  logic                     rob_ready;
  logic [NUM_FU-1:0]        rob_grant;
  logic                     rob_valid;
  logic [ID_W-1:0]          rob_robid;
  logic [DATA_W-1:0]        rob_flags;
  logic [DATA_W-1:0]        rob_wbs;
  logic [DATA_W-1:0]        rob_value;
`ifdef RESULT_ARB_STATS_EN
  logic [7:0]               cdb_conflicts;
  logic [7:0]               rob_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  fu_result_arbiter #(.NUM_FU(NUM_FU), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cdb_req       (cdb_req),
    .cdb_req_id    (cdb_req_id),
    .cdb_req_val   (cdb_req_val),
    .cdb_grant     (cdb_grant),
    .cdb_valid     (cdb_valid),
    .cdb_id        (cdb_id),
    .cdb_val       (cdb_val),
    .rob_req       (rob_req),
    .rob_req_robid (rob_req_robid),
    .rob_req_flags (rob_req_flags),
    .rob_req_wbs   (rob_req_wbs),
    .rob_req_value (rob_req_value),
    .rob_ready     (rob_ready),
    .rob_grant     (rob_grant),
    .rob_valid     (rob_valid),
    .rob_robid     (rob_robid),
    .rob_flags     (rob_flags),
    .rob_wbs       (rob_wbs),
    .rob_value     (rob_value)
`ifdef RESULT_ARB_STATS_EN
    ,
    .cdb_conflicts (cdb_conflicts),
    .rob_conflicts (rob_conflicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-chosen per-FU payloads.
  function automatic logic [3:0] cdb_tag(input int i);  return 4'(8 + i);        endfunction
  function automatic logic [7:0] cdb_dat(input int i);  return 8'(16 * i + 10);  endfunction
  function automatic logic [3:0] rob_id(input int i);   return 4'(4 + i);        endfunction
  function automatic logic [7:0] rob_flg(input int i);  return 8'(8'h20 + i);    endfunction
  function automatic logic [7:0] rob_wb(input int i);   return 8'(8'h40 + i);    endfunction
  function automatic logic [7:0] rob_val(input int i);  return 8'(8'h80 + i);    endfunction

  initial begin
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};

    rst       = 1'b1;
    cdb_req   = 4'b1111;
    rob_req   = 4'b1111;
    rob_ready = 1'b1;
    for (int i = 0; i < NUM_FU; i++) begin
      cdb_req_id[i*ID_W +: ID_W]       = cdb_tag(i);
      cdb_req_val[i*DATA_W +: DATA_W]  = cdb_dat(i);
      rob_req_robid[i*ID_W +: ID_W]    = rob_id(i);
      rob_req_flags[i*DATA_W +: DATA_W] = rob_flg(i);
      rob_req_wbs[i*DATA_W +: DATA_W]  = rob_wb(i);
      rob_req_value[i*DATA_W +: DATA_W] = rob_val(i);
    end

    // Reset held two cycles with every request raised.
    tick();
    tick();
    chk("rst_cdb_grant", 32'(cdb_grant), 32'h0);
    chk("rst_rob_grant", 32'(rob_grant), 32'h0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("rst_rob_valid", 32'(rob_valid), 32'h0);
    chk("rst_cdb_id",    32'(cdb_id),    32'h0);
    chk("rst_cdb_val",   32'(cdb_val),   32'h0);
    chk("rst_rob_payld", {rob_robid, rob_flags, rob_wbs, rob_value[3:0]}, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_cdb_grant", 32'(cdb_grant), 32'b0001);
    chk("first_rob_grant", 32'(rob_grant), 32'b0001);
    tick();
    chk("first_cdb_valid", 32'(cdb_valid), 32'h1);
    chk("first_cdb_id",    32'(cdb_id),    32'(cdb_tag(0)));

    // Re-reset to bring both pointers back to FU0.
    rst     = 1'b1;
    cdb_req = '0;
    rob_req = '0;
    tick();
    rst = 1'b0;

    // Round-robin over four continuous requesters.
    cdb_req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rr_grant%0d", c), 32'(cdb_grant), 32'(1 << rr_exp[c]));
      tick();
      chk($sformatf("rr_id%0d", c),  32'(cdb_id),  32'(cdb_tag(rr_exp[c])));
      chk($sformatf("rr_val%0d", c), 32'(cdb_val), 32'(cdb_dat(rr_exp[c])));
    end

    // Pointer is now 1; steer it to 3 by granting FU2, then check skip and wrap.
    cdb_req = 4'b0100;
    #1;
    chk("sw_pre_grant", 32'(cdb_grant), 32'b0100);
    tick();
    cdb_req = 4'b0101;
    #1;
    chk("sw_grant0", 32'(cdb_grant), 32'b0001);
    tick();
    chk("sw_id0", 32'(cdb_id), 32'(cdb_tag(0)));
    #1;
    chk("sw_grant1", 32'(cdb_grant), 32'b0100);
    tick();
    chk("sw_id1", 32'(cdb_id), 32'(cdb_tag(2)));
    cdb_req = '0;
    #1;
    chk("idle_cdb_grant", 32'(cdb_grant), 32'h0);
    tick();
    chk("idle_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("idle_cdb_hold",  32'(cdb_id),    32'(cdb_tag(2)));

    // ROB backpressure: FU1 waits three cycles for rob_ready.
    rob_req   = 4'b0010;
    rob_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_grant%0d", c), 32'(rob_grant), 32'h0);
      tick();
      chk($sformatf("bp_valid%0d", c), 32'(rob_valid), 32'h0);
    end
    rob_ready = 1'b1;
    #1;
    chk("bp_rel_grant", 32'(rob_grant), 32'b0010);
    tick();
    rob_req = '0;
    chk("bp_rel_valid", 32'(rob_valid), 32'h1);
    chk("bp_rel_payld", {rob_robid, 4'h0, rob_flags, rob_wbs, rob_value},
        {rob_id(1), 4'h0, rob_flg(1), rob_wb(1), rob_val(1)});
    tick();
    chk("bp_after_valid", 32'(rob_valid), 32'h0);
    chk("bp_after_hold",  32'(rob_value), 32'(rob_val(1)));

    // Dual channel: FU2 wins both buses in the same cycle.
    cdb_req_id[2*ID_W +: ID_W]      = 4'd5;
    cdb_req_val[2*DATA_W +: DATA_W] = 8'h3C;
    cdb_req = 4'b0100;
    rob_req = 4'b0100;
    #1;
    chk("dual_cdb_grant", 32'(cdb_grant), 32'b0100);
    chk("dual_rob_grant", 32'(rob_grant), 32'b0100);
    tick();
    cdb_req = '0;
    rob_req = '0;
    chk("dual_cdb_id",    32'(cdb_id),    32'd5);
    chk("dual_cdb_val",   32'(cdb_val),   32'h3C);
    chk("dual_rob_valid", 32'(rob_valid), 32'h1);
    chk("dual_rob_robid", 32'(rob_robid), 32'(rob_id(2)));

    // Reset arriving with a pending request drops the transfer.
    cdb_req = 4'b1000;
    rst     = 1'b1;
    #1;
    chk("midrst_grant", 32'(cdb_grant), 32'h0);
    tick();
    chk("midrst_valid", 32'(cdb_valid), 32'h0);
    chk("midrst_id",    32'(cdb_id),    32'h0);
    rst     = 1'b0;
    cdb_req = '0;
    tick();

`ifdef RESULT_ARB_STATS_EN
    // Two steady CDB requesters: conflict counter must saturate, then clear.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    cdb_req = 4'b0011;
    for (int c = 0; c < 300; c++) tick();
    chk("stat_cdb_sat", 32'(cdb_conflicts), 32'd255);
    chk("stat_rob_zero", 32'(rob_conflicts), 32'd0);
    cdb_req = '0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    chk("stat_cdb_clr", 32'(cdb_conflicts), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fu_result_arbiter.md
# fu_result_arbiter

Shares the two result channels, common data bus (CDB) and reorder-buffer (ROB) writeback, among `NUM_FU` functional units. Each FU presents its result on both channels and waits for a per-channel grant. The arbiter picks one FU per channel per cycle, round-robin, and registers the winner's payload onto the shared bus. It sits between the FU output stages and the reservation stations / ROB.

## Interface
Parameters:
- `NUM_FU`, default 4: number of requesting FUs (2..8).
- `ID_W`, default 4: ROB id width.
- `DATA_W`, default 8: value, flags and wbs width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cdb_req` in `NUM_FU`: FU CDB request (FU's `cdb_transmit_out`).
- `cdb_req_id` in `NUM_FU`x`ID_W`: per-FU CDB tag.
- `cdb_req_val` in `NUM_FU`x`DATA_W`: per-FU CDB value.
- `cdb_grant` out `NUM_FU`: one-hot grant, wired to the FU's `cdb_transmit`.
- `cdb_valid` out 1: shared CDB broadcast valid.
- `cdb_id` out `ID_W`: shared CDB tag.
- `cdb_val` out `DATA_W`: shared CDB value.
- `rob_req` in `NUM_FU`: FU ROB request (FU's `rob_transmit_out`).
- `rob_req_robid` in `NUM_FU`x`ID_W`: per-FU ROB id.
- `rob_req_flags` in `NUM_FU`x`DATA_W`: per-FU flags.
- `rob_req_wbs` in `NUM_FU`x`DATA_W`: per-FU wbs.
- `rob_req_value` in `NUM_FU`x`DATA_W`: per-FU value.
- `rob_ready` in 1: ROB can accept a write this cycle.
- `rob_grant` out `NUM_FU`: one-hot grant, wired to the FU's `rob_transmit`.
- `rob_valid` out 1: ROB write strobe.
- `rob_robid`, `rob_flags`, `rob_wbs`, `rob_value` out: ROB write payload.

## Operation
- The two channels are independent. Each channel has a round-robin pointer `ptr` (log2 `NUM_FU` bits).
- Grant (combinational):
  - Winner is the first set `req` bit scanning `ptr`, `ptr+1`, …, wrapping modulo `NUM_FU`.
  - `grant` is that bit, one-hot. It is all-zero when no request is set.
  - ROB grant is additionally all-zero when `rob_ready`=0.
- On a clock edge where a grant is nonzero:
  - `ptr` becomes winner+1, wrapping at `NUM_FU-1` to 0.
  - The winner's payload is registered to the channel outputs with `valid`=1.
- When a grant is zero: `valid`=0, payload registers hold their value, and `ptr` is unchanged.
- Requester contract:
  - An FU holds `req` and its payload stable until it is granted.
  - It samples `grant` at the same edge and deasserts `req` the next cycle unless it has a new result.
  - An FU may drop `req` without being granted; this is legal and no grant is issued.
- The same FU may win both channels in one cycle.
- `rst` clears both pointers, all `valid` outputs, and all payload registers to 0.
- Reset asserted mid-transfer drops any pending broadcast; no grant is issued during reset.

## Timing
- Grant to output latency is 1 cycle: request sampled at edge N, `grant` high during cycle N, bus `valid` during cycle N+1.
- Throughput is 1 result per channel per cycle. Back-to-back grants to different FUs are allowed.
- A lone requester is granted every cycle it requests.
- Worst-case wait for a continuously requesting FU is `NUM_FU-1` grants, plus cycles with `rob_ready`=0 on the ROB channel.
- `grant` has no combinational dependence on any payload input.

## Configuration
- `RESULT_ARB_STATS_EN` defined adds two outputs:
  - `cdb_conflicts` and `rob_conflicts`, 8 bits each.
  - Each increments on every cycle where more than one `req` bit is set on that channel, or, for ROB, where `rob_req`≠0 while `rob_ready`=0.
  - Each saturates at 255 and is cleared by `rst`.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Shared package `fu_pkg`: `robid_t`, `data_t`, `NUM_FU`, and a `cdb_msg_t` struct (id, val).
- Shared package `fu_pkg` also holds a `rob_msg_t` struct (robid, flags, wbs, value).
- Sub-module `rr_arbiter`, parameterized by width:
  - Ports: `clk`, `rst`, `req`, `en`, `grant`, `grant_idx`, with the pointer held internally.
  - Instantiated twice; the CDB instance has `en`=1 and the ROB instance has `en`=`rob_ready`.
- Output payload muxing and registering stays in the top module.

## Test plan
- Reset: hold `rst` for 2 cycles with all `req`=1. Required: `grant`=0, `valid`=0, payload outputs 0; the first grant after release goes to FU0.
- Round-robin: `cdb_req`=4'b1111 held for 5 cycles. Required: grants 0001, 0010, 0100, 1000, 0001; `cdb_id` follows the granted FU's tag one cycle later.
- Skip and wrap: `ptr`=3, `cdb_req`=4'b0101. Required: grant 0001, then 0100.
- ROB backpressure: `rob_req`=4'b0010, `rob_ready`=0 for 3 cycles, then 1. Required: `rob_grant`=0 and `rob_valid`=0 for 3 cycles; then grant 0010 and `rob_valid`=1 with FU1's payload one cycle later.
- Dual channel: FU2 requests CDB (id 5, val 0x3C) and ROB in the same cycle. Required: both grants 0100; next cycle `cdb_id`=5, `cdb_val`=0x3C, `rob_valid`=1.
- Stats build: `cdb_req`=4'b0011 for 300 cycles. Required: `cdb_conflicts` saturates at 255; `rst` returns it to 0.
